// File: rtl/ycbcr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ycbcr_pkg
//  Description : Shared types and constants for the YCbCr 4:2:2 -> 4:4:4
//                chroma upsampler.
//  Revision    : 1.0 - initial release
// ============================================================================
package ycbcr_pkg;

  // Input-to-output latency of the upsampler, in clock cycles.
  localparam int LATENCY = 4;

  // Alignment state: IDLE drops everything until a line boundary is seen.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Mid-scale chroma code, i.e. "no colour" for unsigned offset-binary chroma.
  function automatic int neutral_chroma(input int data_width);
    return 1 << (data_width - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/delay.sv
`default_nettype none
// ============================================================================
//  Module      : delay
//  Description : Fixed-length register delay line with asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay #(
  parameter int DATA_WIDTH = 1,
  parameter int DELAY_TIME = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] r_pipe [DELAY_TIME];

  // Shift the input through DELAY_TIME registers; reset clears every stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DELAY_TIME; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DELAY_TIME; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_data = r_pipe[DELAY_TIME-1];

endmodule
`default_nettype wire

// File: rtl/convert_ycbcr422to444.sv
`default_nettype none
// ============================================================================
//  Module      : convert_ycbcr422to444
//  Description : Chroma upsampler, YCbCr 4:2:2 (Cb/Cr multiplexed on one bus)
//                to per-pixel Y/Cb/Cr 4:4:4. Odd pixels take averaged or
//                replicated chroma; syncs are delayed to match the data.
//  Revision    : 1.0 - initial release
// ============================================================================
module convert_ycbcr422to444
  import ycbcr_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int INTERP     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data_y,
  input  logic [DATA_WIDTH-1:0] i_data_c,
  input  logic                  i_sync_h,
  input  logic                  i_sync_v,
  output logic [DATA_WIDTH-1:0] o_data_y,
  output logic [DATA_WIDTH-1:0] o_data_cb,
  output logic [DATA_WIDTH-1:0] o_data_cr,
  output logic                  o_sync_h,
  output logic                  o_sync_v
);

  localparam logic [DATA_WIDTH-1:0] c_neutral   = DATA_WIDTH'(neutral_chroma(DATA_WIDTH));
  localparam bit                    c_interp_en = (INTERP != 0);

  // Rounded mean of two samples, computed one bit wider so it never wraps.
  function automatic logic [DATA_WIDTH-1:0] round_avg(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return DATA_WIDTH'(({1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, 1'b1}) >> 1);
  endfunction

  state_t r_state;
  state_t w_state_next;

  logic w_pix_valid;
  logic w_in_valid;
  logic r_phase;

  // Look-ahead pipeline. Index 0 is the youngest stage. When the pixel under
  // decision sits in stage 2, stages 1 and 0 hold the next two pixels and
  // stage 3 holds the previous one.
  logic [3:0]            r_vld;
  logic [2:0]            r_ph;
  logic [DATA_WIDTH-1:0] r_y [3];
  logic [DATA_WIDTH-1:0] r_c [4];

  logic [DATA_WIDTH-1:0] w_y;
  logic [DATA_WIDTH-1:0] w_cb;
  logic [DATA_WIDTH-1:0] w_cr;
  logic [DATA_WIDTH-1:0] r_out_y;
  logic [DATA_WIDTH-1:0] r_out_cb;
  logic [DATA_WIDTH-1:0] r_out_cr;

  logic [1:0] w_sync_in;
  logic [1:0] w_sync_out;

  // Frame blanking overrides line valid.
  assign w_pix_valid = i_sync_h & i_sync_v;
  // Pixels arriving before the first line boundary after reset are dropped.
  assign w_in_valid  = w_pix_valid & (r_state == RUN);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Leave IDLE on the first non-valid cycle so a partial line is never used.
  always_comb begin
    w_state_next = r_state;
    if ((r_state == IDLE) && !w_pix_valid) begin
      w_state_next = RUN;
    end
  end

  // Phase restarts at 0 on every blanking cycle and toggles per valid pixel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= 1'b0;
    end else begin
      r_phase <= w_in_valid ? ~r_phase : 1'b0;
    end
  end

  // Advance the look-ahead pipeline; non-valid slots carry zero data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
      r_ph  <= '0;
      for (int i = 0; i < 3; i++) begin
        r_y[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        r_c[i] <= '0;
      end
    end else begin
      r_vld  <= {r_vld[2:0], w_in_valid};
      r_ph   <= {r_ph[1:0], r_phase & w_in_valid};
      r_y[0] <= w_in_valid ? i_data_y : '0;
      r_c[0] <= w_in_valid ? i_data_c : '0;
      for (int i = 1; i < 3; i++) begin
        r_y[i] <= r_y[i-1];
      end
      for (int i = 1; i < 4; i++) begin
        r_c[i] <= r_c[i-1];
      end
    end
  end

  // Pick chroma for the pixel in stage 2 from its neighbours in the line.
  always_comb begin
    w_y  = '0;
    w_cb = '0;
    w_cr = '0;
    if (r_vld[2]) begin
      w_y = r_y[2];
      if (!r_ph[2]) begin
        // Even pixel: own Cb; Cr from the next pixel, else the previous
        // pair's Cr, else neutral for a one-pixel line.
        w_cb = r_c[2];
        if (r_vld[1]) begin
          w_cr = r_c[1];
        end else if (r_vld[3]) begin
          w_cr = r_c[3];
        end else begin
          w_cr = c_neutral;
        end
      end else begin
        // Odd pixel: pair chroma by default, blended with the next pair
        // whenever that pair's samples exist in the same line.
        w_cb = r_c[3];
        w_cr = r_c[2];
        if (c_interp_en && r_vld[1]) begin
          w_cb = round_avg(r_c[3], r_c[1]);
          if (r_vld[0]) begin
            w_cr = round_avg(r_c[2], r_c[0]);
          end
        end
      end
    end
  end

  // Output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_y  <= '0;
      r_out_cb <= '0;
      r_out_cr <= '0;
    end else begin
      r_out_y  <= w_y;
      r_out_cb <= w_cb;
      r_out_cr <= w_cr;
    end
  end

  // Line sync is suppressed while IDLE so a discarded partial line stays dark.
  assign w_sync_in = {i_sync_v, i_sync_h & (r_state == RUN)};

  delay #(
    .DATA_WIDTH (2),
    .DELAY_TIME (LATENCY)
  ) u_sync_delay (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (w_sync_in),
    .o_data (w_sync_out)
  );

  assign o_data_y  = r_out_y;
  assign o_data_cb = r_out_cb;
  assign o_data_cr = r_out_cr;
  assign o_sync_h  = w_sync_out[0];
  assign o_sync_v  = w_sync_out[1];

endmodule
`default_nettype wire
